// File: rtl/clint_timer_if.sv
// LSU <-> CLINT single-beat request/response bus.
// A beat transfers on the rising edge where valid and ready are both high; once valid is raised the
// sender holds it and its payload stable until that edge.
interface clint_timer_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wstrb;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/clint_timer.sv
// Core-local interruptor: mtime, mtimecmp and msip registers behind a single-beat LSU port,
// producing the registered machine timer and software interrupt lines.
module clint_timer #(
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0200_0000,
  parameter int unsigned TICK_DIV  = 1
) (
  input  logic          clk,
  input  logic          rst,
  clint_timer_if.slave  bus,
  output logic          clint_mtip,
  output logic          clint_msip,
  output logic          o_dbg_state
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } state_t;

  localparam logic [15:0] DIV_M1 = 16'(TICK_DIV - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_req_ready;
  logic        w_resp_valid;
  logic        w_accept;

  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;
  logic        r_msip;
  logic [15:0] r_presc;
  logic [63:0] r_rdata;
  logic        r_err;
  logic        r_mtip;
  logic        r_msip_q;

  logic [63:0] w_offset;
  logic        w_aligned;
  logic        w_sel_msip;
  logic        w_sel_cmp;
  logic        w_sel_time;
  logic        w_err;
  logic [63:0] w_wmask;
  logic [63:0] w_rd_val;
  logic        w_tick;
  logic        w_wr_msip;
  logic        w_wr_cmp;
  logic        w_wr_time;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_req_ready  = 1'b0;
    w_resp_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_req_ready = 1'b1;
        if (bus.req_valid) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        w_resp_valid = 1'b1;
        if (bus.resp_ready) w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign w_accept = w_req_ready & bus.req_valid;

  // Addresses below BASE wrap to huge offsets, so one subtraction covers both region bounds.
  assign w_offset   = bus.req_addr - BASE_ADDR;
  assign w_aligned  = (bus.req_addr[2:0] == 3'b000);
  assign w_sel_msip = w_aligned && (w_offset == 64'h0000);
  assign w_sel_cmp  = w_aligned && (w_offset == 64'h4000);
  assign w_sel_time = w_aligned && (w_offset == 64'hBFF8);
  assign w_err      = !(w_sel_msip || w_sel_cmp || w_sel_time);

  always_comb begin
    w_wmask = '0;
    for (int i = 0; i < 8; i++) begin
      w_wmask[i*8 +: 8] = {8{bus.req_wstrb[i]}};
    end
  end

  always_comb begin
    w_rd_val = '0;
    if (w_sel_msip)      w_rd_val = {63'b0, r_msip};
    else if (w_sel_cmp)  w_rd_val = r_mtimecmp;
    else if (w_sel_time) w_rd_val = r_mtime;
  end

  assign w_wr_msip = w_accept && bus.req_we && w_sel_msip;
  assign w_wr_cmp  = w_accept && bus.req_we && w_sel_cmp;
  assign w_wr_time = w_accept && bus.req_we && w_sel_time;
  assign w_tick    = (r_presc == DIV_M1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_presc <= '0;
    else      r_presc <= w_tick ? 16'd0 : r_presc + 16'd1;
  end

  // A store to mtime overrides the tick; unstrobed bytes keep their pre-tick value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           r_mtime <= '0;
    else if (w_wr_time) r_mtime <= (r_mtime & ~w_wmask) | (bus.req_wdata & w_wmask);
    else if (w_tick)    r_mtime <= r_mtime + 64'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mtimecmp <= '1;
      r_msip     <= 1'b0;
    end else begin
      if (w_wr_cmp)  r_mtimecmp <= (r_mtimecmp & ~w_wmask) | (bus.req_wdata & w_wmask);
      if (w_wr_msip && bus.req_wstrb[0]) r_msip <= bus.req_wdata[0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_rdata <= (bus.req_we || w_err) ? 64'd0 : w_rd_val;
      r_err   <= w_err;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mtip   <= 1'b0;
      r_msip_q <= 1'b0;
    end else begin
      r_mtip   <= (r_mtime >= r_mtimecmp);
      r_msip_q <= r_msip;
    end
  end

  assign bus.req_ready  = w_req_ready;
  assign bus.resp_valid = w_resp_valid;
  assign bus.resp_rdata = r_rdata;
  assign bus.resp_err   = r_err;
  assign clint_mtip     = r_mtip;
  assign clint_msip     = r_msip_q;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_clint_timer.sv
// Bench for clint_timer: a TICK_DIV=1 instance for the bus/interrupt tests and a TICK_DIV=4
// instance for prescaler and tick/store collision behaviour.
module tb_clint_timer;

  localparam logic [63:0] A_MSIP = 64'h0200_0000;
  localparam logic [63:0] A_CMP  = 64'h0200_4000;
  localparam logic [63:0] A_TIME = 64'h0200_BFF8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  clint_timer_if b1 ();
  clint_timer_if b4 ();

  logic mtip1, msip1, st1, mtip4, msip4, st4;

  clint_timer #(.TICK_DIV(1)) u_dut (
    .clk(clk), .rst(rst), .bus(b1),
    .clint_mtip(mtip1), .clint_msip(msip1), .o_dbg_state(st1)
  );

  clint_timer #(.BASE_ADDR(64'h0000_0000_0200_0000), .TICK_DIV(4)) u_dut4 (
    .clk(clk), .rst(rst), .bus(b4),
    .clint_mtip(mtip4), .clint_msip(msip4), .o_dbg_state(st4)
  );

  // Edges since reset release; at a negedge it equals the index of the next edge.
  int unsigned cnt;
  always @(posedge clk or negedge rst) begin
    if (!rst) cnt <= 0;
    else      cnt <= cnt + 1;
  end

  int checks = 0;
  int errors = 0;
  logic [64:0] exp_q[$];

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic [63:0] rdata;
    logic        err;
    logic        msip;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge with the block back in IDLE.
  task automatic xfer(input bit sel, input logic we, input logic [63:0] addr,
                      input logic [63:0] wdata, input logic [7:0] wstrb,
                      input logic [63:0] er, input logic ee, input string nm);
    int n;
    logic rv;
    logic [64:0] e;
    exp_q.push_back({ee, er});
    if (sel) begin
      b4.req_valid = 1'b1; b4.req_we = we; b4.req_addr = addr;
      b4.req_wdata = wdata; b4.req_wstrb = wstrb;
    end else begin
      b1.req_valid = 1'b1; b1.req_we = we; b1.req_addr = addr;
      b1.req_wdata = wdata; b1.req_wstrb = wstrb;
    end
    n = 0;
    while (!(sel ? b4.req_ready : b1.req_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    if (sel) b4.req_valid = 1'b0;
    else     b1.req_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      rv = sel ? b4.resp_valid : b1.resp_valid;
      n++;
    end while (!rv && n < 20);
    e = exp_q.pop_front();
    if (!rv) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: resp_valid got 0 expected 1", nm);
    end else begin
      chk({nm, " rdata"}, sel ? b4.resp_rdata : b1.resp_rdata, e[63:0]);
      chk({nm, " err"}, {63'b0, (sel ? b4.resp_err : b1.resp_err)}, {63'b0, e[64]});
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_phase(input int unsigned p);
    int n;
    n = 0;
    while ((cnt % 4) != p && n < 8) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, " req_ready"},  {63'b0, b1.req_ready},  64'd1);
    chk({nm, " resp_valid"}, {63'b0, b1.resp_valid}, 64'd0);
    chk({nm, " resp_rdata"}, b1.resp_rdata,          64'd0);
    chk({nm, " resp_err"},   {63'b0, b1.resp_err},   64'd0);
    chk({nm, " mtip"},       {63'b0, mtip1},         64'd0);
    chk({nm, " msip"},       {63'b0, msip1},         64'd0);
    chk({nm, " state"},      {63'b0, st1},           64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: sim time exceeded");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [64:0] e;

    vecs[0]  = '{1'b1, A_MSIP, 64'hFFFF_FFFF, 8'h01, 64'h0, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, A_MSIP, 64'h0, 8'h00, 64'h1, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, A_MSIP, 64'h0, 8'h01, 64'h0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, A_MSIP, 64'h0, 8'h00, 64'h0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 64'h0200_0008, 64'h0, 8'h00, 64'h0, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 64'h0200_BFFC, 64'h0, 8'h00, 64'h0, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 64'h0300_0000, {$urandom, $urandom}, 8'hFF, 64'h0, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 64'h0200_4004, {$urandom, $urandom}, 8'hFF, 64'h0, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 64'h0201_4000, 64'h0, 8'h00, 64'h0, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 64'h0200_0001, 64'h0, 8'h00, 64'h0, 1'b1, 1'b0};
    vecs[10] = '{1'b0, A_CMP, 64'h0, 8'h00, 64'h0000_0000_0000_FFFF, 1'b0, 1'b0};
    vecs[11] = '{1'b1, A_MSIP, 64'h1, 8'h00, 64'h0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, A_MSIP, 64'h0, 8'h00, 64'h0, 1'b0, 1'b0};
    vecs[13] = '{1'b1, A_CMP, 64'hAABB_CCDD_0000_0000, 8'hF0, 64'h0, 1'b0, 1'b0};
    vecs[14] = '{1'b0, A_CMP, 64'h0, 8'h00, 64'hAABB_CCDD_0000_FFFF, 1'b0, 1'b0};

    b1.req_valid = 1'b0; b1.req_we = 1'b0; b1.req_addr = '0; b1.req_wdata = '0;
    b1.req_wstrb = '0;   b1.resp_ready = 1'b1;
    b4.req_valid = 1'b0; b4.req_we = 1'b0; b4.req_addr = '0; b4.req_wdata = '0;
    b4.req_wstrb = '0;   b4.resp_ready = 1'b1;

    // Reset state, then mtime counts exactly the edges since release.
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    chk("reset dut4 mtip", {63'b0, mtip4}, 64'd0);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    xfer(1'b0, 1'b0, A_TIME, 64'h0, 8'h00, 64'(cnt), 1'b0, "t1 mtime");
    chk("t1 mtip", {63'b0, mtip1}, 64'd0);

    // Timer compare: rise three edges after the mtime store, fall after raising mtimecmp.
    xfer(1'b0, 1'b1, A_CMP,  64'h20, 8'hFF, 64'h0, 1'b0, "t2 st cmp");
    xfer(1'b0, 1'b1, A_TIME, 64'h1E, 8'hFF, 64'h0, 1'b0, "t2 st time");
    chk("t2 mtip edge1", {63'b0, mtip1}, 64'd0);
    @(negedge clk);
    chk("t2 mtip edge2", {63'b0, mtip1}, 64'd0);
    @(negedge clk);
    chk("t2 mtip edge3", {63'b0, mtip1}, 64'd1);
    xfer(1'b0, 1'b1, A_CMP, 64'hFFFF, 8'hFF, 64'h0, 1'b0, "t2 st cmp2");
    chk("t2 mtip fall", {63'b0, mtip1}, 64'd0);

    for (int i = 0; i < 15; i++) begin
      xfer(1'b0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb,
           vecs[i].rdata, vecs[i].err, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d msip", i), {63'b0, msip1}, {63'b0, vecs[i].msip});
    end
    chk("table mtip", {63'b0, mtip1}, 64'd0);

    // Prescaler: store on a tick edge wins, wrap to 0 on the next tick, partial store on a tick.
    wait_phase(3);
    xfer(1'b1, 1'b1, A_TIME, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'h0, 1'b0, "t5 st max");
    xfer(1'b1, 1'b0, A_TIME, 64'h0, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, "t5 ld max");
    wait_phase(0);
    xfer(1'b1, 1'b0, A_TIME, 64'h0, 8'h00, 64'h0, 1'b0, "t5 ld wrap");
    wait_phase(3);
    xfer(1'b1, 1'b1, A_TIME, 64'h1234_5678, 8'h0F, 64'h0, 1'b0, "t5 st part");
    xfer(1'b1, 1'b0, A_TIME, 64'h0, 8'h00, 64'h0000_0000_1234_5678, 1'b0, "t5 ld part");

    // Stalled response, a second request that must not be taken, then reset mid-RESP.
    b1.resp_ready = 1'b0;
    exp_q.push_back({1'b0, 64'hAABB_CCDD_0000_FFFF});
    b1.req_valid = 1'b1; b1.req_we = 1'b0; b1.req_addr = A_CMP; b1.req_wstrb = 8'h00;
    @(posedge clk);
    #1;
    b1.req_we = 1'b1; b1.req_addr = A_MSIP; b1.req_wdata = 64'h1; b1.req_wstrb = 8'h01;
    e = exp_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("t6 stall%0d valid", i), {63'b0, b1.resp_valid}, 64'd1);
      chk($sformatf("t6 stall%0d rdata", i), b1.resp_rdata, e[63:0]);
      chk($sformatf("t6 stall%0d ready", i), {63'b0, b1.req_ready}, 64'd0);
    end
    chk("t6 stall err", {63'b0, b1.resp_err}, {63'b0, e[64]});
    chk("t6 second req ignored", {63'b0, msip1}, 64'd0);
    rst = 1'b0;
    b1.req_valid = 1'b0;
    #1;
    chk_reset_outputs("t6 rst");
    b1.resp_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    xfer(1'b0, 1'b0, A_CMP,  64'h0, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, "t6 cmp rst");
    xfer(1'b0, 1'b0, A_MSIP, 64'h0, 8'h00, 64'h0, 1'b0, "t6 msip rst");
    xfer(1'b0, 1'b0, A_TIME, 64'h0, 8'h00, 64'(cnt), 1'b0, "t6 mtime rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
